// File: rtl/capture_pkg.sv
// Shared types and defaults for the line-sensor capture scheduler.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    CAPTURE,
    DONE
  } cap_state_t;

  localparam int CAPTURE_CYCLES = 577;
  // Slot floor leaves a small handoff margin after a full capture.
  localparam int DEF_MIN_PERIOD = CAPTURE_CYCLES + 23;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse; the pulse appears three clocks after the input edge.
module trig_sync_edge (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic pulse_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      pulse_reg <= sync2_reg && !prev_reg;
    end
  end

  assign rise_pulse = pulse_reg;

endmodule

// File: rtl/capture_scheduler.sv
// Capture slot scheduler with ping-pong line-buffer ownership tracking.
// Define CAPTURE_TIMEOUT_EN to enable the CAPTURE-state watchdog.
module capture_scheduler
  import capture_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                mode,
  input  logic                ext_trig,
  input  logic [PERIOD_W-1:0] period,
  input  logic                capture_complete,
  input  logic [1:0]          buf_free,
  input  logic                err_clr,
  output logic                start_capture,
  output logic                buf_sel,
  output logic                frame_ready,
  output logic                frame_buf,
  output logic [CNT_W-1:0]    frame_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic                overrun,
  output logic                timeout_err,
  output logic                busy
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

  cap_state_t          state_reg, state_next;
  logic [PERIOD_W-1:0] cnt_reg;
  logic [PERIOD_W-1:0] load_val;
  logic                buf_sel_reg;
  logic                last_buf_reg;
  logic                frame_buf_reg;
  logic                overrun_reg;
  logic [1:0]          held_reg;
  logic [1:0]          held_next;
  logic [CNT_W-1:0]    frame_count_reg;
  logic [CNT_W-1:0]    drop_count_reg;
  logic                ext_pulse;
  logic                tick_per;
  logic                tick;
  logic                pick_buf;
  logic                any_free;
  logic                launch;
  logic                drop_evt;
  logic                timeout_hit;

  trig_sync_edge u_ext_sync (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .async_in   (ext_trig),
    .rise_pulse (ext_pulse)
  );

  assign load_val = (period < MIN_P) ? (MIN_P - PERIOD_W'(1)) : (period - PERIOD_W'(1));
  assign tick_per = enable && !mode && (state_reg != IDLE) && (cnt_reg == '0);
  assign tick     = mode ? (enable && ext_pulse) : tick_per;

  // The slot counter free-runs through START/CAPTURE/DONE so slots stay on a
  // fixed grid; it only reloads from IDLE, when paused, or on its own tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!enable || mode || (state_reg == IDLE) || (cnt_reg == '0)) begin
      cnt_reg <= load_val;
    end else begin
      cnt_reg <= cnt_reg - PERIOD_W'(1);
    end
  end

  assign any_free = ~&held_reg;
  assign pick_buf = held_reg[~last_buf_reg] ? last_buf_reg : ~last_buf_reg;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_reg;
  logic            timeout_err_reg;

  assign timeout_hit = (state_reg == CAPTURE) && (wd_reg == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wd_reg          <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wd_reg          <= (state_reg == CAPTURE) ? (wd_reg + WD_W'(1)) : '0;
      timeout_err_reg <= (timeout_hit && !capture_complete) || (timeout_err_reg && !err_clr);
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    drop_evt   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (tick) begin
          if (any_free) begin
            launch     = 1'b1;
            state_next = START;
          end else begin
            drop_evt = 1'b1;
          end
        end
      end
      START: begin
        drop_evt   = tick;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        drop_evt = tick;
        if (capture_complete) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = enable ? ARMED : IDLE;
        end
      end
      DONE: begin
        drop_evt   = tick;
        state_next = enable ? ARMED : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A buffer marked held by DONE stays held even if released that same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign held_next[gi] = ((state_reg == DONE) && (buf_sel_reg == 1'(gi))) ||
                             (held_reg[gi] && !buf_free[gi]);
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      buf_sel_reg     <= 1'b0;
      last_buf_reg    <= 1'b1;
      frame_buf_reg   <= 1'b0;
      held_reg        <= 2'b00;
      frame_count_reg <= '0;
      drop_count_reg  <= '0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
      if (launch) buf_sel_reg <= pick_buf;
      if ((state_reg == CAPTURE) && capture_complete) frame_buf_reg <= buf_sel_reg;
      if (state_reg == DONE) begin
        last_buf_reg    <= buf_sel_reg;
        frame_count_reg <= frame_count_reg + CNT_W'(1);
      end
      overrun_reg <= drop_evt || (overrun_reg && !err_clr);
      if (drop_evt) begin
        if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + CNT_W'(1);
      end else if (err_clr) begin
        drop_count_reg <= '0;
      end
    end
  end

  assign start_capture = (state_reg == START);
  assign frame_ready   = (state_reg == DONE);
  assign busy          = (state_reg == START) || (state_reg == CAPTURE) || (state_reg == DONE);
  assign buf_sel       = buf_sel_reg;
  assign frame_buf     = frame_buf_reg;
  assign frame_count   = frame_count_reg;
  assign drop_count    = drop_count_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed bench for capture_scheduler with start/frame scoreboards, a
// capture-engine model and a consumer model.
module tb_capture_scheduler;

  localparam int PERIOD_W = 16;
  localparam int CNT_W    = 16;

  logic                clk_in = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                mode = 1'b0;
  logic                ext_trig = 1'b0;
  logic [PERIOD_W-1:0] period = 16'd1000;
  logic                capture_complete;
  logic [1:0]          buf_free;
  logic                err_clr = 1'b0;
  logic                start_capture;
  logic                buf_sel;
  logic                frame_ready;
  logic                frame_buf;
  logic [CNT_W-1:0]    frame_count;
  logic [CNT_W-1:0]    drop_count;
  logic                overrun;
  logic                timeout_err;
  logic                busy;

  logic       cc_main = 1'b0;
  logic       cc_eng = 1'b0;
  logic [1:0] bf_main = 2'b00;
  logic [1:0] bf_cons = 2'b00;
  bit         engine_on = 1'b1;
  bit         auto_free = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    int   cyc;
    logic b;
  } exp_t;

  exp_t exp_q[$];
  logic exp_frame_q[$];

  assign capture_complete = cc_main | cc_eng;
  assign buf_free         = bf_main | bf_cons;

  capture_scheduler #(
    .PERIOD_W    (PERIOD_W),
    .MIN_PERIOD  (600),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .enable           (enable),
    .mode             (mode),
    .ext_trig         (ext_trig),
    .period           (period),
    .capture_complete (capture_complete),
    .buf_free         (buf_free),
    .err_clr          (err_clr),
    .start_capture    (start_capture),
    .buf_sel          (buf_sel),
    .frame_ready      (frame_ready),
    .frame_buf        (frame_buf),
    .frame_count      (frame_count),
    .drop_count       (drop_count),
    .overrun          (overrun),
    .timeout_err      (timeout_err),
    .busy             (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_start(input int c, input logic b, input bit completes);
    exp_t e;
    e.cyc = c;
    e.b   = b;
    exp_q.push_back(e);
    if (completes) exp_frame_q.push_back(b);
  endtask

  task automatic wait_fc(input int target, input int budget, input string tag);
    int n = 0;
    while ((int'(frame_count) != target) && (n < budget)) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, 64'(frame_count), 64'(target));
  endtask

  task automatic ext_edge(input int hold);
    ext_trig = 1'b1;
    repeat (hold) @(negedge clk_in);
    ext_trig = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, 64'({start_capture, buf_sel, frame_ready, frame_buf, frame_count,
                  drop_count, overrun, timeout_err, busy}), 64'd0);
  endtask

  // Start scoreboard: every start_capture pulse must match the next expectation.
  always @(negedge clk_in) begin : mon_start
    exp_t e;
    if (rst_n && start_capture) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL start_unexpected observed_cyc=%0d expected=none", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("start_cycle", 64'(cyc), 64'(e.cyc));
        chk("start_buf", 64'(buf_sel), 64'(e.b));
      end
    end
  end

  // Frame scoreboard: every frame_ready must match the next expected buffer.
  always @(negedge clk_in) begin : mon_frame
    logic b;
    if (rst_n && frame_ready) begin
      checks++;
      assert (exp_frame_q.size() != 0) else begin
        failures++;
        $error("FAIL frame_unexpected observed_cyc=%0d expected=none", cyc);
      end
      if (exp_frame_q.size() != 0) begin
        b = exp_frame_q.pop_front();
        chk("frame_buf", 64'(frame_buf), 64'(b));
      end
    end
  end

  // Capture engine: completion 580 clocks after the start pulse.
  initial begin : engine
    forever begin
      @(negedge clk_in);
      if (start_capture && engine_on) begin
        repeat (579) @(negedge clk_in);
        cc_eng = 1'b1;
        @(negedge clk_in);
        cc_eng = 1'b0;
      end
    end
  end

  // Consumer: releases each delivered buffer 50 clocks later.
  initial begin : consumer
    logic b;
    forever begin
      @(negedge clk_in);
      if (frame_ready && auto_free) begin
        b = frame_buf;
        repeat (50) @(negedge clk_in);
        bf_cons[b] = 1'b1;
        @(negedge clk_in);
        bf_cons = 2'b00;
      end
    end
  end

  initial begin : main
    int c0;
    int k;
    int n;

    repeat (3) @(negedge clk_in);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk_in);

    // Power-up completion pulse in IDLE is ignored.
    cc_main = 1'b1;
    @(negedge clk_in);
    cc_main = 1'b0;
    @(negedge clk_in);
    chk("pwrup_cc_ignored", 64'({busy, frame_ready, frame_count}), 64'd0);

    // Periodic, period 1000.
    period = 16'd1000;
    mode   = 1'b0;
    c0     = cyc;
    for (int i = 0; i < 4; i++) expect_start(c0 + 1 + 1000 * (i + 1), 1'(i % 2), 1'b1);
    enable = 1'b1;
    wait_fc(4, 5000, "periodic_frames");
    enable = 1'b0;
    chk("periodic_overrun", 64'(overrun), 64'd0);
    chk("periodic_drops", 64'(drop_count), 64'd0);
    repeat (100) @(negedge clk_in);

    // Period below the floor is clamped to 600.
    period = 16'd10;
    c0     = cyc;
    for (int i = 0; i < 3; i++) expect_start(c0 + 1 + 600 * (i + 1), 1'(i % 2), 1'b1);
    enable = 1'b1;
    wait_fc(7, 3000, "clamp_frames");
    enable = 1'b0;
    repeat (100) @(negedge clk_in);

    // Consumer stall.
    rst_n = 1'b0;
    @(negedge clk_in);
    check_all_zero("reset_after_run");
    rst_n     = 1'b1;
    auto_free = 1'b0;
    period    = 16'd600;
    c0        = cyc;
    expect_start(c0 + 601, 1'b0, 1'b1);
    expect_start(c0 + 1201, 1'b1, 1'b1);
    enable = 1'b1;
    n = 0;
    while (!overrun && (n < 2500)) begin
      @(negedge clk_in);
      n++;
    end
    chk("stall_overrun_cyc", 64'(cyc), 64'(c0 + 1801));
    chk("stall_drop_count", 64'(drop_count), 64'd1);
    chk("stall_frames", 64'(frame_count), 64'd2);
    expect_start(c0 + 2401, 1'b0, 1'b1);
    bf_main = 2'b01;
    @(negedge clk_in);
    bf_main = 2'b00;
    wait_fc(3, 1500, "stall_resume_frames");
    enable = 1'b0;
    chk("stall_drop_hold", 64'(drop_count), 64'd1);
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    chk("errclr_overrun", 64'(overrun), 64'd0);
    chk("errclr_drops", 64'(drop_count), 64'd0);
    bf_main = 2'b11;
    @(negedge clk_in);
    bf_main   = 2'b00;
    auto_free = 1'b1;

    // External trigger.
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n  = 1'b1;
    mode   = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk_in);
    cc_main = 1'b1;
    @(negedge clk_in);
    cc_main = 1'b0;
    @(negedge clk_in);
    chk("armed_cc_ignored", 64'({busy, frame_count}), 64'd0);
    k = cyc;
    expect_start(k + 4, 1'b0, 1'b1);
    ext_edge(10);
    repeat (100) @(negedge clk_in);
    ext_edge(10);
    chk("ext_drop_count", 64'(drop_count), 64'd1);
    chk("ext_drop_overrun", 64'(overrun), 64'd1);
    wait_fc(1, 1000, "ext_frames");

    // Enable falls mid-capture: frame still delivered, then idle.
    repeat (60) @(negedge clk_in);
    k = cyc;
    expect_start(k + 4, 1'b1, 1'b1);
    ext_edge(5);
    repeat (100) @(negedge clk_in);
    enable = 1'b0;
    wait_fc(2, 1000, "disable_frames");
    @(negedge clk_in);
    chk("disable_busy", 64'(busy), 64'd0);
    ext_edge(10);
    repeat (20) @(negedge clk_in);
    chk("disable_no_start_busy", 64'(busy), 64'd0);
    chk("disable_drop_hold", 64'(drop_count), 64'd1);

    // Capture engine stops answering.
    repeat (60) @(negedge clk_in);
    engine_on = 1'b0;
    enable    = 1'b1;
    repeat (3) @(negedge clk_in);
    k = cyc;
    expect_start(k + 4, 1'b0, 1'b0);
    ext_edge(5);
`ifdef CAPTURE_TIMEOUT_EN
    n = 0;
    while (!timeout_err && (n < 1200)) begin
      @(negedge clk_in);
      n++;
    end
    chk("timeout_cycle", 64'(cyc), 64'(k + 4 + 1025));
    chk("timeout_frames", 64'(frame_count), 64'd2);
    chk("timeout_busy", 64'(busy), 64'd0);
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    chk("timeout_clr", 64'(timeout_err), 64'd0);
    k = cyc;
    expect_start(k + 4, 1'b0, 1'b0);
    ext_edge(5);
    repeat (100) @(negedge clk_in);
`else
    repeat (1100) @(negedge clk_in);
    chk("nowd_busy", 64'(busy), 64'd1);
    chk("nowd_timeout_err", 64'(timeout_err), 64'd0);
`endif
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_capture");
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);

    chk("sb_starts_pending", 64'(exp_q.size()), 64'd0);
    chk("sb_frames_pending", 64'(exp_frame_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
